// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calc_pkg
// Brief   : Shared types, key codes and widths for the calculator sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int OPERAND_W = 7;
    localparam int RESULT_W  = 14;
    localparam int KEY_W     = 4;

    localparam logic [KEY_W-1:0] KEY_ADD = 4'd10;
    localparam logic [KEY_W-1:0] KEY_SUB = 4'd11;
    localparam logic [KEY_W-1:0] KEY_MUL = 4'd12;
    localparam logic [KEY_W-1:0] KEY_DIV = 4'd13;
    localparam logic [KEY_W-1:0] KEY_EQ  = 4'd14;
    localparam logic [KEY_W-1:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_CALC    = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [KEY_W-1:0] k);
        return (k >= KEY_ADD) && (k <= KEY_DIV);
    endfunction

    // Operator keys map onto the op encoding by subtracting the ADD key code.
    function automatic alu_op_e key_to_op(input logic [KEY_W-1:0] k);
        return alu_op_e'(2'(k - KEY_ADD));
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : calc_sequencer_if
// Brief   : Operand/operation request and completion bus to the external ALU.
// Revision: 1.0 - initial release
// ============================================================================
interface calc_sequencer_if;
    import calc_pkg::*;

    logic [OPERAND_W-1:0] operand_a;
    logic [OPERAND_W-1:0] operand_b;
    logic [1:0]           alu_op;
    logic                 alu_start;
    logic                 alu_done;
    logic                 alu_err;
    logic [RESULT_W-1:0]  alu_result;

    modport master (
        output operand_a, operand_b, alu_op, alu_start,
        input  alu_done, alu_err, alu_result
    );

    modport slave (
        input  operand_a, operand_b, alu_op, alu_start,
        output alu_done, alu_err, alu_result
    );

endinterface
`default_nettype wire

// File: rtl/key_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : key_edge_detect
// Brief   : One-cycle pulse on the rising edge of a synchronous level.
// Revision: 1.0 - initial release
// ============================================================================
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic r_level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= level;
        end
    end

    assign pulse = level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : calc_sequencer
// Brief   : Keypad-driven two-operand calculator sequencer for an external ALU.
// Revision: 1.0 - initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int ALU_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [KEY_W-1:0]    key_code,
    calc_sequencer_if.master    alu,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid,
    output logic                led_a,
    output logic                led_b,
    output logic                err
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

    state_e               r_state;
    logic [OPERAND_W-1:0] r_operand_a;
    logic [OPERAND_W-1:0] r_operand_b;
    alu_op_e              r_alu_op;
    logic                 r_alu_start;
    logic [1:0]           r_count_a;
    logic [1:0]           r_count_b;
    logic [CNT_W-1:0]     r_calc_cnt;

    logic                 w_key_evt;
    logic [OPERAND_W-1:0] w_digit;
    logic [OPERAND_W-1:0] w_a_shift;
    logic [OPERAND_W-1:0] w_b_shift;

    key_edge_detect u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .level (key_valid),
        .pulse (w_key_evt)
    );

    // Digits are only accepted while the count is below two, so the shift cannot overflow.
    assign w_digit   = OPERAND_W'(key_code);
    assign w_a_shift = r_operand_a * 7'd10 + w_digit;
    assign w_b_shift = r_operand_b * 7'd10 + w_digit;

    assign alu.operand_a = r_operand_a;
    assign alu.operand_b = r_operand_b;
    assign alu.alu_op    = r_alu_op;
    assign alu.alu_start = r_alu_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ENTER_A;
            r_operand_a  <= '0;
            r_operand_b  <= '0;
            r_alu_op     <= OP_ADD;
            r_alu_start  <= 1'b0;
            r_count_a    <= 2'd0;
            r_count_b    <= 2'd0;
            r_calc_cnt   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            {led_a, led_b, err} <= 3'b100;
        end else begin
            r_alu_start <= 1'b0;
            // Clear outranks everything, including a completion arriving this cycle.
            if (w_key_evt && (key_code == KEY_CLR)) begin
                r_state      <= ST_ENTER_A;
                r_operand_a  <= '0;
                r_operand_b  <= '0;
                r_alu_op     <= OP_ADD;
                r_count_a    <= 2'd0;
                r_count_b    <= 2'd0;
                r_calc_cnt   <= '0;
                result       <= '0;
                result_valid <= 1'b0;
                {led_a, led_b, err} <= 3'b100;
            end else begin
                case (r_state)
                    ST_ENTER_A: begin
                        if (w_key_evt) begin
                            if (is_digit(key_code)) begin
                                if (r_count_a != 2'd2) begin
                                    r_operand_a <= w_a_shift;
                                    r_count_a   <= r_count_a + 2'd1;
                                end
                            end else if (is_op(key_code) && (r_count_a != 2'd0)) begin
                                r_alu_op    <= key_to_op(key_code);
                                r_operand_b <= '0;
                                r_count_b   <= 2'd0;
                                r_state     <= ST_ENTER_B;
                                {led_a, led_b, err} <= 3'b010;
                            end
                        end
                    end
                    ST_ENTER_B: begin
                        if (w_key_evt) begin
                            if (is_digit(key_code)) begin
                                if (r_count_b != 2'd2) begin
                                    r_operand_b <= w_b_shift;
                                    r_count_b   <= r_count_b + 2'd1;
                                end
                            end else if (is_op(key_code)) begin
                                if (r_count_b == 2'd0) begin
                                    r_alu_op <= key_to_op(key_code);
                                end
                            end else if ((key_code == KEY_EQ) && (r_count_b != 2'd0)) begin
                                r_alu_start <= 1'b1;
                                r_calc_cnt  <= '0;
                                r_state     <= ST_CALC;
                                {led_a, led_b, err} <= 3'b000;
                            end
                        end
                    end
                    ST_CALC: begin
                        if (alu.alu_done) begin
                            if (!alu.alu_err) begin
                                result       <= alu.alu_result;
                                result_valid <= 1'b1;
                                r_state      <= ST_SHOW;
                            end else begin
                                r_state <= ST_ERROR;
                                {led_a, led_b, err} <= 3'b001;
                            end
                        end else if (r_calc_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
                            r_state <= ST_ERROR;
                            {led_a, led_b, err} <= 3'b001;
                        end else begin
                            r_calc_cnt <= r_calc_cnt + 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (w_key_evt && is_digit(key_code)) begin
                            r_operand_a  <= w_digit;
                            r_count_a    <= 2'd1;
                            r_operand_b  <= '0;
                            r_count_b    <= 2'd0;
                            result_valid <= 1'b0;
                            r_state      <= ST_ENTER_A;
                            {led_a, led_b, err} <= 3'b100;
                        end
                    end
                    ST_ERROR: begin
                        r_state <= ST_ERROR;
                    end
                    default: begin
                        r_state <= ST_ENTER_A;
                        {led_a, led_b, err} <= 3'b100;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_calc_sequencer
// Brief   : Directed self-checking bench for calc_sequencer with a simple ALU model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] result;
    logic        result_valid;
    logic        led_a;
    logic        led_b;
    logic        err;

    bit          alu_en       = 1'b0;
    bit          alu_resp_err = 1'b0;
    logic [13:0] alu_resp_val = '0;
    int          start_cnt    = 0;
    int          n_total      = 0;
    int          n_fail       = 0;

    calc_sequencer_if bus ();

    calc_sequencer #(.ALU_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .alu          (bus.master),
        .result       (result),
        .result_valid (result_valid),
        .led_a        (led_a),
        .led_b        (led_b),
        .err          (err)
    );

    always #5 clk = ~clk;

    // ALU model: answers three cycles after seeing alu_start, when enabled.
    initial begin
        bus.alu_done   = 1'b0;
        bus.alu_err    = 1'b0;
        bus.alu_result = '0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                start_cnt++;
                if (alu_en) begin
                    repeat (2) @(negedge clk);
                    bus.alu_done   = 1'b1;
                    bus.alu_err    = alu_resp_err;
                    bus.alu_result = alu_resp_val;
                    @(negedge clk);
                    bus.alu_done   = 1'b0;
                    bus.alu_err    = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        key_code  = code;
        key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] flags();
        return 32'({led_a, led_b, err, result_valid, bus.alu_start});
    endfunction

    initial begin
        int t;
        int base;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_flags", flags(), 32'b10000);
        check("reset_a", 32'(bus.operand_a), 0);
        check("reset_result", 32'(result), 0);
        rst = 1'b0;
        @(negedge clk);

        // 42 + 17 = 59
        press(4'd10, 1);
        check("op_count0_ignored", flags(), 32'b10000);
        press(4'd4, 1);
        press(4'd2, 1);
        check("a_42", 32'(bus.operand_a), 42);
        press(4'd10, 1);
        check("enter_b_flags", flags(), 32'b01000);
        press(4'd1, 1);
        press(4'd7, 1);
        press(4'd12, 1);
        check("b_17", 32'(bus.operand_b), 17);
        check("op_add_kept", 32'(bus.alu_op), 0);
        alu_en       = 1'b1;
        alu_resp_err = 1'b0;
        alu_resp_val = 14'd59;
        base         = start_cnt;
        press(4'd14, 1);
        t = 0;
        while (!result_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("result_wait_timeout", 32'(t < 20), 1);
        check("show_flags", flags(), 32'b00010);
        check("result_59", 32'(result), 59);
        check("ops_held", 32'({bus.operand_a, bus.operand_b}), 32'({7'd42, 7'd17}));
        repeat (5) @(negedge clk);
        check("one_start", 32'(start_cnt - base), 1);

        // Digit from SHOW restarts operand A; then a two-digit limit and op replace
        press(4'd3, 1);
        check("show_digit_a", 32'(bus.operand_a), 3);
        check("show_digit_flags", flags(), 32'b10000);
        press(4'd3, 1);
        press(4'd9, 1);
        check("a_33_third_digit_ignored", 32'(bus.operand_a), 33);
        press(4'd10, 1);
        press(4'd11, 1);
        check("op_replaced_sub", 32'(bus.alu_op), 1);
        press(4'd14, 1);
        check("eq_count0_ignored", flags(), 32'b01000);

        // Asynchronous reset mid-ENTER_B
        rst = 1'b1;
        #1;
        check("async_rst_flags", flags(), 32'b10000);
        check("async_rst_ops", 32'({bus.operand_a, bus.operand_b, bus.alu_op}), 0);
        check("async_rst_result", 32'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Held key yields one event; digit sequence 1,2,3 -> 12
        press(4'd5, 20);
        check("held_key_a5", 32'(bus.operand_a), 5);
        press(4'd15, 1);
        press(4'd1, 1);
        press(4'd2, 1);
        press(4'd3, 1);
        check("a_12", 32'(bus.operand_a), 12);
        press(4'd15, 1);

        // 8 / 0 with ALU error
        alu_resp_err = 1'b1;
        press(4'd8, 1);
        press(4'd13, 1);
        press(4'd0, 1);
        press(4'd14, 1);
        t = 0;
        while (!err && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("err_wait_timeout", 32'(t < 20), 1);
        check("error_flags", flags(), 32'b00100);
        press(4'd5, 1);
        check("error_digit_ignored", 32'(bus.operand_a), 8);
        check("error_result_kept", 32'(result), 0);
        press(4'd15, 1);
        check("clear_flags", flags(), 32'b10000);
        check("clear_ops", 32'({bus.operand_a, bus.operand_b, bus.alu_op}), 0);

        // Timeout: no alu_done ever
        alu_en       = 1'b0;
        alu_resp_err = 1'b0;
        base         = start_cnt;
        press(4'd2, 1);
        press(4'd10, 1);
        press(4'd3, 1);
        key_code  = 4'd14;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        check("calc_entered", flags(), 32'b00001);
        t = 0;
        while (!err && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("timeout_cycles", 32'(t), 16);
        @(negedge clk);
        check("timeout_one_start", 32'(start_cnt - base), 1);
        press(4'd15, 1);

        // Clear coinciding with alu_done
        alu_en       = 1'b1;
        alu_resp_val = 14'd42;
        press(4'd6, 1);
        press(4'd12, 1);
        press(4'd7, 1);
        key_code  = 4'd14;
        key_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.alu_start && t < 5);
        check("start_seen", 32'(bus.alu_start), 1);
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
        key_code  = 4'd15;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("clr_vs_done_flags", flags(), 32'b10000);
        check("clr_vs_done_result", 32'(result), 0);
        repeat (3) @(negedge clk);
        check("late_done_ignored", flags(), 32'b10000);
        check("clr_vs_done_a", 32'(bus.operand_a), 0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
`default_nettype wire
